pb_burst_write_responder: RTL

- Target-side responder for page-bounded AXI-style write bursts, as issued by the serial-link/JTAG preload path into L2 memory tiles.
- Accepts one write-address request and its data beats, then writes each beat to a single-port SRAM request/grant interface.
- Checks each burst for protocol legality: 4 KiB page crossing, oversize beats and WLAST placement.
- Returns one write response per burst.

---
 rtl/pb_burst_write_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pb_burst_write_responder.sv
// Page-bounded INCR write-burst responder driving a single-port SRAM req/gnt port.
// Define PB_BURST_RESP_STATS_EN to add beats_written_o / err_count_o counters.
module pb_burst_write_responder #(
  parameter  int AddrWidth = 48,
  parameter  int DataWidth = 64,
  parameter  int IdWidth   = 4,
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic [7:0]           aw_len_i,
  input  logic [2:0]           aw_size_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0] w_strb_i,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbWidth-1:0] mem_strb_o
`ifdef PB_BURST_RESP_STATS_EN
  ,
  output logic [31:0]          beats_written_o,
  output logic [15:0]          err_count_o
`endif
);
  localparam int Lsb = $clog2(StrbWidth);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DRAIN,
    RESP
  } state_e;

  state_e               state_q;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] addr_d;
  logic [7:0]           len_q;
  logic [7:0]           cnt_q;
  logic [2:0]           size_q;
  logic                 err_q;

  logic [11:0] pg_off;
  logic [19:0] pg_end;
  logic        err_size;
  logic        err_page;
  logic        beat_done;

  always_comb begin
    // Page end is measured from the size-aligned start, in bytes.
    pg_off   = aw_addr_i[11:0] & (12'hFFF << aw_size_i);
    pg_end   = {8'd0, pg_off}
             + ({11'd0, {1'b0, aw_len_i} + 9'd1} << aw_size_i);
    err_page = pg_end > 20'd4096;
    err_size = aw_size_i > 3'(Lsb);
    addr_d   = (addr_q & ({AddrWidth{1'b1}} << size_q))
             + (AddrWidth'(1) << size_q);
  end

  assign beat_done   = (state_q == DATA) && w_valid_i
                    && mem_gnt_i && !rst_i;
  assign aw_ready_o  = (state_q == IDLE) && !rst_i;
  assign w_ready_o   = ((state_q == DRAIN) && !rst_i) || beat_done;
  assign mem_req_o   = (state_q == DATA) && w_valid_i && !rst_i;
  assign mem_addr_o  = addr_q & ({AddrWidth{1'b1}} << Lsb);
  assign mem_wdata_o = w_data_i;
  assign mem_strb_o  = w_strb_i;
  assign b_valid_o   = state_q == RESP;
  assign b_id_o      = id_q;
  assign b_resp_o    = (state_q == RESP && err_q) ? 2'b10 : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_valid_i) begin
            id_q    <= aw_id_i;
            addr_q  <= aw_addr_i;
            len_q   <= aw_len_i;
            size_q  <= aw_size_i;
            cnt_q   <= '0;
            err_q   <= err_size || err_page;
            state_q <= (err_size || err_page) ? DRAIN : DATA;
          end
        end
        DATA: begin
          if (beat_done) begin
            addr_q <= addr_d;
            if (cnt_q != len_q) cnt_q <= cnt_q + 8'd1;
            if (w_last_i) begin
              if (cnt_q != len_q) err_q <= 1'b1;
              state_q <= RESP;
            end else if (cnt_q == len_q) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_valid_i && w_last_i) state_q <= RESP;
        end
        RESP: begin
          if (b_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PB_BURST_RESP_STATS_EN
  logic [31:0] beats_q;
  logic [15:0] errs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beats_q <= '0;
      errs_q  <= '0;
    end else begin
      if (beat_done) beats_q <= beats_q + 32'd1;
      if (b_valid_o && b_ready_i && err_q && errs_q != 16'hFFFF)
        errs_q <= errs_q + 16'd1;
    end
  end

  assign beats_written_o = beats_q;
  assign err_count_o     = errs_q;
`endif
endmodule
